// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer_if
// Description : Update, lookup and counter bundle between the branch/load
//               controller, the fetch stage and the branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_buffer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 2
);
    logic [DATA_W-1:0] PC_fetch;
    logic [DATA_W-1:0] PC_out_ID_RF;
    logic              BP_write_enable;
    logic [DATA_W-1:0] PC_BP_in;
    logic [DATA_W-1:0] BTA_BP_in;
    logic              H_BP_in;
    logic [CNT_W:0]    add_BP_in;
    logic              enable1;
    logic              enable2;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;
    logic [CNT_W+1:0]  add_BP_out;
    logic [CNT_W-1:0]  count1;
    logic [CNT_W-1:0]  count2;

    modport master (
        output PC_fetch, PC_out_ID_RF, BP_write_enable, PC_BP_in, BTA_BP_in,
               H_BP_in, add_BP_in, enable1, enable2,
        input  pred_taken, pred_target, add_BP_out, count1, count2
    );

    modport slave (
        input  PC_fetch, PC_out_ID_RF, BP_write_enable, PC_BP_in, BTA_BP_in,
               H_BP_in, add_BP_in, enable1, enable2,
        output pred_taken, pred_target, add_BP_out, count1, count2
    );
endinterface
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : 8-entry BTB (BEQ class 0-3, JAL class 4-7) with fetch-side
//               prediction, ID_RF-side hit/index lookup and per-class victim counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    branch_target_buffer_if.slave  bus
);
    localparam int IDX_W   = CNT_W + 1;
    localparam int ENTRIES = 2 ** IDX_W;

    logic              valid_q [ENTRIES];
    logic [DATA_W-1:0] tag_q   [ENTRIES];
    logic [DATA_W-1:0] bta_q   [ENTRIES];
    logic              hist_q  [ENTRIES];
    logic [CNT_W-1:0]  count1_q, count1_d;
    logic [CNT_W-1:0]  count2_q, count2_d;

    logic              fetch_hit;
    logic [IDX_W-1:0]  fetch_idx;
    logic              idrf_hit;
    logic [IDX_W-1:0]  idrf_idx;

    always_comb begin
        count1_d = bus.enable1 ? count1_q + 1'b1 : count1_q;
        count2_d = bus.enable2 ? count2_q + 1'b1 : count2_q;
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        fetch_hit = 1'b0;
        fetch_idx = '0;
        idrf_hit  = 1'b0;
        idrf_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == bus.PC_fetch)) begin
                fetch_hit = 1'b1;
                fetch_idx = i[IDX_W-1:0];
            end
            if (valid_q[i] && (tag_q[i] == bus.PC_out_ID_RF)) begin
                idrf_hit = 1'b1;
                idrf_idx = i[IDX_W-1:0];
            end
        end
    end

    // Gating with reset keeps outputs quiet during reset independent of array clear timing.
    always_comb begin
        bus.pred_taken  = reset & fetch_hit & hist_q[fetch_idx];
        bus.pred_target = bus.pred_taken ? bta_q[fetch_idx] : '0;
        bus.add_BP_out  = (reset & idrf_hit) ? {1'b1, idrf_idx} : '0;
        bus.count1      = count1_q;
        bus.count2      = count2_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                bta_q[i]   <= '0;
                hist_q[i]  <= 1'b0;
            end
            count1_q <= '0;
            count2_q <= '0;
        end else begin
            if (bus.BP_write_enable) begin
                valid_q[bus.add_BP_in] <= 1'b1;
                tag_q[bus.add_BP_in]   <= bus.PC_BP_in;
                bta_q[bus.add_BP_in]   <= bus.BTA_BP_in;
                hist_q[bus.add_BP_in]  <= bus.H_BP_in;
            end
            count1_q <= count1_d;
            count2_q <= count2_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Table-driven self-checking bench for branch_target_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;
    logic clock;
    logic reset;

    branch_target_buffer_if #(.DATA_W(16), .CNT_W(2)) bus ();

    branch_target_buffer #(.DATA_W(16), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] fetch;
        logic [15:0] idrf;
        logic        we;
        logic [15:0] pcin;
        logic [15:0] btain;
        logic        hin;
        logic [2:0]  addin;
        logic        en1;
        logic        en2;
        logic        taken;
        logic [15:0] target;
        logic [3:0]  add;
        logic [1:0]  c1;
        logic [1:0]  c2;
    } vec_t;

    localparam int NROWS = 14;
    vec_t tbl [NROWS];
    vec_t sb  [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic [15:0] fetch, input logic [15:0] idrf,
        input logic we, input logic [15:0] pcin, input logic [15:0] btain,
        input logic hin, input logic [2:0] addin, input logic en1, input logic en2,
        input logic taken, input logic [15:0] target, input logic [3:0] add,
        input logic [1:0] c1, input logic [1:0] c2);
        vec_t v;
        v.fetch = fetch; v.idrf = idrf; v.we = we; v.pcin = pcin; v.btain = btain;
        v.hin = hin; v.addin = addin; v.en1 = en1; v.en2 = en2;
        v.taken = taken; v.target = target; v.add = add; v.c1 = c1; v.c2 = c2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.PC_fetch        = v.fetch;
        bus.PC_out_ID_RF    = v.idrf;
        bus.BP_write_enable = v.we;
        bus.PC_BP_in        = v.pcin;
        bus.BTA_BP_in       = v.btain;
        bus.H_BP_in         = v.hin;
        bus.add_BP_in       = v.addin;
        bus.enable1         = v.en1;
        bus.enable2         = v.en2;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, " pred_taken"},  {31'd0, bus.pred_taken}, {31'd0, e.taken});
        chk({tag, " pred_target"}, {16'd0, bus.pred_target}, {16'd0, e.target});
        chk({tag, " add_BP_out"},  {28'd0, bus.add_BP_out}, {28'd0, e.add});
        chk({tag, " count1"},      {30'd0, bus.count1}, {30'd0, e.c1});
        chk({tag, " count2"},      {30'd0, bus.count2}, {30'd0, e.c2});
    endtask

    initial begin
        vec_t e;
        vec_t idle;

        //            fetch     idrf     we pcin     bta      h addr en1 en2  tk tgt      add      c1 c2
        tbl[0]  = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0);
        tbl[1]  = mk(16'h0010, 16'h0010, 1, 16'h0010, 16'h0040, 1, 3'd2, 1, 0, 0, 16'h0000, 4'b0000, 0, 0);
        tbl[2]  = mk(16'h0010, 16'h0010, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 1, 16'h0040, 4'b1010, 1, 0);
        tbl[3]  = mk(16'h0010, 16'h0010, 1, 16'h0010, 16'h0040, 0, 3'd2, 0, 0, 1, 16'h0040, 4'b1010, 1, 0);
        tbl[4]  = mk(16'h0010, 16'h0010, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 1, 0, 16'h0000, 4'b1010, 1, 0);
        tbl[5]  = mk(16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 1, 0, 16'h0000, 4'b0000, 1, 1);
        tbl[6]  = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 1, 0, 16'h0000, 4'b0000, 1, 2);
        tbl[7]  = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 1, 0, 16'h0000, 4'b0000, 1, 3);
        tbl[8]  = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 1, 0, 16'h0000, 4'b0000, 1, 0);
        tbl[9]  = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 1, 1, 0, 16'h0000, 4'b0000, 1, 1);
        tbl[10] = mk(16'h0000, 16'h0000, 1, 16'h0020, 16'h0500, 1, 3'd5, 0, 0, 0, 16'h0000, 4'b0000, 2, 2);
        tbl[11] = mk(16'h0020, 16'h0020, 1, 16'h0020, 16'h0100, 1, 3'd1, 0, 0, 1, 16'h0500, 4'b1101, 2, 2);
        tbl[12] = mk(16'h0020, 16'h0020, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 1, 16'h0100, 4'b1001, 2, 2);
        tbl[13] = mk(16'h0099, 16'h0040, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 0, 0, 16'h0000, 4'b0000, 2, 2);

        idle = mk(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 0,
                  0, 16'h0000, 4'b0000, 0, 0);

        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs("reset", idle);
        reset = 1'b1;

        // Rows apply before an edge and are checked before that edge commits them.
        for (int r = 0; r < NROWS; r++) begin
            @(posedge clock);
            #1;
            drive(tbl[r]);
            sb.push_back(tbl[r]);
            @(negedge clock);
            e = sb.pop_front();
            check_outputs($sformatf("row%0d", r), e);
        end

        // Asynchronous reset between edges with live hits in the table.
        @(posedge clock);
        #1;
        drive(idle);
        bus.PC_fetch     = 16'h0020;
        bus.PC_out_ID_RF = 16'h0020;
        #2;
        chk("prereset pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        chk("prereset add_BP_out", {28'd0, bus.add_BP_out}, 32'h9);
        reset = 1'b0;
        #1;
        check_outputs("async_reset", idle);

        // A write held across an edge while reset is low must not land.
        bus.BP_write_enable = 1'b1;
        bus.PC_BP_in        = 16'h0030;
        bus.BTA_BP_in       = 16'h0300;
        bus.H_BP_in         = 1'b1;
        bus.add_BP_in       = 3'd3;
        bus.enable1         = 1'b1;
        @(posedge clock);
        #1;
        drive(idle);
        @(negedge clock);
        reset = 1'b1;
        #1;
        bus.PC_fetch     = 16'h0030;
        bus.PC_out_ID_RF = 16'h0030;
        #1;
        check_outputs("post_reset_0030", idle);
        bus.PC_fetch     = 16'h0020;
        bus.PC_out_ID_RF = 16'h0010;
        #1;
        check_outputs("post_reset_0020", idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
